// File: rtl/mp_adder_serial.sv
// ============================================================================
// Module   : mp_adder_serial
// Brief    : Word-serial multi-precision adder/subtractor, one ADDER_WIDTH
//            chunk per cycle (LS chunk first), start/busy/done handshake.
//            Optional macro MP_ADDER_OVERFLOW_EN adds the oOverflow port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mp_adder_serial #(
   parameter int OPERAND_WIDTH = 256,
   parameter int ADDER_WIDTH   = 32
) (
   input  logic                     iClk,
   input  logic                     iRstn,
   input  logic                     iStart,
   input  logic                     iSub,
   input  logic [OPERAND_WIDTH-1:0] iA,
   input  logic [OPERAND_WIDTH-1:0] iB,
   input  logic                     iCarryIn,
   output logic                     oBusy,
   output logic                     oDone,
   output logic [OPERAND_WIDTH-1:0] oResult,
   output logic                     oCarryOut
`ifdef MP_ADDER_OVERFLOW_EN
   ,
   output logic                     oOverflow
`endif
);

   localparam int NUM_CHUNKS = OPERAND_WIDTH / ADDER_WIDTH;
   localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHUNKS - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                     state_q,   state_d;
   logic [OPERAND_WIDTH-1:0]   a_q,       a_d;
   logic [OPERAND_WIDTH-1:0]   b_q,       b_d;
   logic [OPERAND_WIDTH-1:0]   partial_q, partial_d;
   logic [OPERAND_WIDTH-1:0]   result_q,  result_d;
   logic                       carry_q,   carry_d;
   logic                       cout_q,    cout_d;
   logic [CNT_W-1:0]           cnt_q,     cnt_d;
`ifdef MP_ADDER_OVERFLOW_EN
   logic                       ovf_q,     ovf_d;
`endif

   logic [ADDER_WIDTH:0]       w_chunk_sum;
   logic [OPERAND_WIDTH-1:0]   w_partial_next;

   // Operands shift right each RUN cycle so the active chunk is always at the LSBs.
   assign w_chunk_sum = {1'b0, a_q[ADDER_WIDTH-1:0]}
                      + {1'b0, b_q[ADDER_WIDTH-1:0]}
                      + {{ADDER_WIDTH{1'b0}}, carry_q};

   always_comb begin
      w_partial_next = partial_q >> ADDER_WIDTH;
      w_partial_next[OPERAND_WIDTH-1 -: ADDER_WIDTH] = w_chunk_sum[ADDER_WIDTH-1:0];
   end

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      partial_d = partial_q;
      result_d  = result_q;
      carry_d   = carry_q;
      cout_d    = cout_q;
      cnt_d     = cnt_q;
`ifdef MP_ADDER_OVERFLOW_EN
      ovf_d     = ovf_q;
`endif

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (iStart) begin
               a_d       = iA;
               b_d       = iSub ? ~iB : iB;
               carry_d   = iSub ? 1'b1 : iCarryIn;
               cnt_d     = '0;
               partial_d = '0;
               state_d   = ST_RUN;
            end else begin
               state_d   = ST_IDLE;
            end
         end

         ST_RUN: begin
            a_d       = a_q >> ADDER_WIDTH;
            b_d       = b_q >> ADDER_WIDTH;
            partial_d = w_partial_next;
            carry_d   = w_chunk_sum[ADDER_WIDTH];
            cnt_d     = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
               result_d = w_partial_next;
               cout_d   = w_chunk_sum[ADDER_WIDTH];
`ifdef MP_ADDER_OVERFLOW_EN
               // Same-sign operands giving a different-sign result is the
               // carry-in(MSB) XOR carry-out(MSB) condition.
               ovf_d    = (a_q[ADDER_WIDTH-1] == b_q[ADDER_WIDTH-1]) &&
                          (w_chunk_sum[ADDER_WIDTH-1] != a_q[ADDER_WIDTH-1]);
`endif
               cnt_d    = '0;
               state_d  = ST_DONE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge iClk or negedge iRstn) begin
      if (!iRstn) begin
         state_q   <= ST_IDLE;
         a_q       <= '0;
         b_q       <= '0;
         partial_q <= '0;
         result_q  <= '0;
         carry_q   <= 1'b0;
         cout_q    <= 1'b0;
         cnt_q     <= '0;
`ifdef MP_ADDER_OVERFLOW_EN
         ovf_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         partial_q <= partial_d;
         result_q  <= result_d;
         carry_q   <= carry_d;
         cout_q    <= cout_d;
         cnt_q     <= cnt_d;
`ifdef MP_ADDER_OVERFLOW_EN
         ovf_q     <= ovf_d;
`endif
      end
   end

   assign oBusy     = (state_q == ST_RUN);
   assign oDone     = (state_q == ST_DONE);
   assign oResult   = result_q;
   assign oCarryOut = cout_q;
`ifdef MP_ADDER_OVERFLOW_EN
   assign oOverflow = ovf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mp_adder_serial.sv
// ============================================================================
// Module   : tb_mp_adder_serial
// Brief    : Self-checking bench for mp_adder_serial (64-bit operands, 16-bit
//            chunks); honours MP_ADDER_OVERFLOW_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mp_adder_serial;

   localparam int OW = 64;
   localparam int AW = 16;
   localparam int NC = OW / AW;

   logic          iClk = 1'b0;
   logic          iRstn;
   logic          iStart;
   logic          iSub;
   logic [OW-1:0] iA;
   logic [OW-1:0] iB;
   logic          iCarryIn;
   logic          oBusy;
   logic          oDone;
   logic [OW-1:0] oResult;
   logic          oCarryOut;
`ifdef MP_ADDER_OVERFLOW_EN
   logic          oOverflow;
`endif

   int checks = 0;
   int errors = 0;

   always #5 iClk = ~iClk;

   mp_adder_serial #(
      .OPERAND_WIDTH(OW),
      .ADDER_WIDTH  (AW)
   ) dut (
      .iClk     (iClk),
      .iRstn    (iRstn),
      .iStart   (iStart),
      .iSub     (iSub),
      .iA       (iA),
      .iB       (iB),
      .iCarryIn (iCarryIn),
      .oBusy    (oBusy),
      .oDone    (oDone),
      .oResult  (oResult),
      .oCarryOut(oCarryOut)
`ifdef MP_ADDER_OVERFLOW_EN
      ,
      .oOverflow(oOverflow)
`endif
   );

   // ---------------- reference model (plain wide arithmetic) ----------------
   function automatic logic [OW-1:0] ref_result(input logic [OW-1:0] a, b,
                                                input logic sub, cin);
      if (sub) return a - b;
      return a + b + {{(OW-1){1'b0}}, cin};
   endfunction

   function automatic logic ref_carry(input logic [OW-1:0] a, b, input logic sub, cin);
      logic [OW:0] t;
      if (sub) return (a >= b);
      t = {1'b0, a} + {1'b0, b} + {{OW{1'b0}}, cin};
      return t[OW];
   endfunction

   function automatic logic ref_ovf(input logic [OW-1:0] a, b, input logic sub, cin);
`ifdef MP_ADDER_OVERFLOW_EN
      logic signed [OW+1:0] sa, sb, s, hi, lo;
      sa = $signed({{2{a[OW-1]}}, a});
      sb = $signed({{2{b[OW-1]}}, b});
      hi = $signed({3'b000, {(OW-1){1'b1}}});
      lo = $signed({3'b111, {(OW-1){1'b0}}});
      s  = sub ? (sa - sb) : (sa + sb + $signed({{(OW+1){1'b0}}, cin}));
      return (s > hi) || (s < lo);
`else
      return 1'b0 & a[0] & b[0] & sub & cin;
`endif
   endfunction

   function automatic logic obs_ovf();
`ifdef MP_ADDER_OVERFLOW_EN
      return oOverflow;
`else
      return 1'b0;
`endif
   endfunction

   task automatic tick();
      @(posedge iClk);
      #1;
   endtask

   // Drives one operation, scrambles inputs after the start edge, and reports
   // what was observed at the first oDone sample (or after a 20-cycle bound).
   task automatic run_op(input logic [OW-1:0] a, b, input logic sub, cin,
                         output logic [OW-1:0] res, output logic co, output logic ov,
                         output int lat, output int nbusy, output bit held);
      logic [OW-1:0] prev;
      prev     = oResult;
      iA       = a;
      iB       = b;
      iSub     = sub;
      iCarryIn = cin;
      iStart   = 1'b1;
      tick();
      iStart   = 1'b0;
      iA       = {$urandom, $urandom};
      iB       = {$urandom, $urandom};
      iSub     = 1'($urandom);
      iCarryIn = 1'($urandom);
      lat      = 0;
      nbusy    = 0;
      held     = 1'b1;
      while (oDone !== 1'b1 && lat < 20) begin
         if (oBusy === 1'b1) nbusy++;
         if (oResult !== prev) held = 1'b0;
         tick();
         lat++;
      end
      res = oResult;
      co  = oCarryOut;
      ov  = obs_ovf();
   endtask

   // ------------------------------- tests -----------------------------------
   task automatic test_reset();
      iStart = 1'b0; iSub = 1'b0; iA = '0; iB = '0; iCarryIn = 1'b0;
      iRstn  = 1'b1;
      #1 iRstn = 1'b0;
      #1;
      checks++;
      if ({oBusy, oDone, oCarryOut, obs_ovf()} !== 4'b0000 || oResult !== '0) begin
         errors++;
         $display("FAIL reset_async: busy=%b done=%b res=%h co=%b ovf=%b expected all 0",
                  oBusy, oDone, oResult, oCarryOut, obs_ovf());
      end
      tick(); tick();
      checks++;
      if ({oBusy, oDone, oCarryOut, obs_ovf()} !== 4'b0000 || oResult !== '0) begin
         errors++;
         $display("FAIL reset_held: busy=%b done=%b res=%h co=%b expected all 0",
                  oBusy, oDone, oResult, oCarryOut);
      end
      iRstn = 1'b1;
      tick();
   endtask

   task automatic test_carry_chain();
      logic [OW-1:0] r; logic co, ov; int lat, nb; bit held;
      run_op(64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0, r, co, ov, lat, nb, held);
      checks++;
      if (r !== 64'h0000_0001_0000_0000 || co !== 1'b0) begin
         errors++;
         $display("FAIL carry_chain: got %h/%b expected 0000000100000000/0", r, co);
      end
      checks++;
      if (lat !== NC) begin
         errors++;
         $display("FAIL carry_chain_latency: got %0d expected %0d", lat, NC);
      end
      checks++;
      if (nb !== NC) begin
         errors++;
         $display("FAIL busy_cycles: got %0d expected %0d", nb, NC);
      end
      checks++;
      if (!held) begin
         errors++;
         $display("FAIL result_hold_during_run: got changed expected held");
      end
      tick();
      checks++;
      if (oDone !== 1'b0 || oBusy !== 1'b0) begin
         errors++;
         $display("FAIL done_pulse: got done=%b busy=%b expected 0/0", oDone, oBusy);
      end
   endtask

   task automatic test_wrap();
      logic [OW-1:0] r; logic co, ov; int lat, nb; bit held;
      run_op({OW{1'b1}}, '0, 1'b0, 1'b1, r, co, ov, lat, nb, held);
      checks++;
      if (r !== '0 || co !== 1'b1 || ov !== 1'b0) begin
         errors++;
         $display("FAIL wrap: got %h/%b/%b expected 0/1/0", r, co, ov);
      end
      tick();
   endtask

   task automatic test_sub();
      logic [OW-1:0] r; logic co, ov; int lat, nb; bit held;
      run_op(64'd5, 64'd7, 1'b1, 1'b1, r, co, ov, lat, nb, held);
      checks++;
      if (r !== 64'hFFFF_FFFF_FFFF_FFFE || co !== 1'b0) begin
         errors++;
         $display("FAIL sub_borrow: got %h/%b expected fffffffffffffffe/0", r, co);
      end
      tick();
      run_op(64'd7, 64'd5, 1'b1, 1'b0, r, co, ov, lat, nb, held);
      checks++;
      if (r !== 64'd2 || co !== 1'b1) begin
         errors++;
         $display("FAIL sub_noborrow: got %h/%b expected 2/1", r, co);
      end
      tick();
   endtask

   task automatic test_overflow();
`ifdef MP_ADDER_OVERFLOW_EN
      logic [OW-1:0] r; logic co, ov; int lat, nb; bit held;
      run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, r, co, ov, lat, nb, held);
      checks++;
      if (r !== 64'h8000_0000_0000_0000 || co !== 1'b0 || ov !== 1'b1) begin
         errors++;
         $display("FAIL signed_overflow: got %h/%b/%b expected 8000000000000000/0/1",
                  r, co, ov);
      end
      tick();
`endif
   endtask

   task automatic test_ignored_start();
      logic [OW-1:0] a, b, exp_r;
      int lat;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      exp_r = ref_result(a, b, 1'b0, 1'b0);
      iA = a; iB = b; iSub = 1'b0; iCarryIn = 1'b0; iStart = 1'b1;
      tick();
      iStart = 1'b0;
      tick();
      iA = ~a; iB = a; iSub = 1'b1; iStart = 1'b1;
      tick();
      iStart = 1'b0;
      lat = 2;
      while (oDone !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
      checks++;
      if (lat !== NC || oResult !== exp_r) begin
         errors++;
         $display("FAIL ignored_start: got lat=%0d res=%h expected lat=%0d res=%h",
                  lat, oResult, NC, exp_r);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (oBusy !== 1'b0 || oDone !== 1'b0) begin
            errors++;
            $display("FAIL no_queued_start: got busy=%b done=%b expected 0/0", oBusy, oDone);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [OW-1:0] r, a, b; logic co, ov; int lat, nb; bit held;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      run_op(a, b, 1'b1, 1'b0, r, co, ov, lat, nb, held);
      checks++;
      if (r !== ref_result(a, b, 1'b1, 1'b0) || co !== ref_carry(a, b, 1'b1, 1'b0)) begin
         errors++;
         $display("FAIL b2b_first: got %h/%b expected %h/%b", r, co,
                  ref_result(a, b, 1'b1, 1'b0), ref_carry(a, b, 1'b1, 1'b0));
      end
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      iA = a; iB = b; iSub = 1'b0; iCarryIn = 1'b1; iStart = 1'b1;
      tick();
      iStart = 1'b0;
      lat = 1;
      while (oDone !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
      checks++;
      if (lat !== NC + 1) begin
         errors++;
         $display("FAIL b2b_spacing: got %0d expected %0d", lat, NC + 1);
      end
      checks++;
      if (oResult !== ref_result(a, b, 1'b0, 1'b1) || oCarryOut !== ref_carry(a, b, 1'b0, 1'b1)) begin
         errors++;
         $display("FAIL b2b_second: got %h/%b expected %h/%b", oResult, oCarryOut,
                  ref_result(a, b, 1'b0, 1'b1), ref_carry(a, b, 1'b0, 1'b1));
      end
   endtask

   task automatic test_hold_stable();
      logic [OW-1:0] r0; logic c0;
      r0 = oResult;
      c0 = oCarryOut;
      for (int i = 0; i < 12; i++) begin
         iA = {$urandom, $urandom};
         iB = {$urandom, $urandom};
         iSub = 1'($urandom);
         iCarryIn = 1'($urandom);
         tick();
         checks++;
         if (oResult !== r0 || oCarryOut !== c0) begin
            errors++;
            $display("FAIL hold_stable: got %h/%b expected %h/%b", oResult, oCarryOut, r0, c0);
         end
      end
   endtask

   task automatic test_reset_mid_run();
      logic [OW-1:0] r, a, b; logic co, ov; int lat, nb; bit held; bit saw_done;
      iA = {OW{1'b1}}; iB = 64'h1234; iSub = 1'b0; iCarryIn = 1'b1; iStart = 1'b1;
      tick();
      iStart = 1'b0;
      tick(); tick();
      iRstn = 1'b0;
      #1;
      checks++;
      if ({oBusy, oDone, oCarryOut, obs_ovf()} !== 4'b0000 || oResult !== '0) begin
         errors++;
         $display("FAIL reset_mid_run: busy=%b done=%b res=%h co=%b expected all 0",
                  oBusy, oDone, oResult, oCarryOut);
      end
      tick(); tick();
      iRstn = 1'b1;
      saw_done = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (oDone === 1'b1 || oBusy === 1'b1) saw_done = 1'b1;
      end
      checks++;
      if (saw_done) begin
         errors++;
         $display("FAIL reset_abort: got activity after reset expected none");
      end
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      run_op(a, b, 1'b0, 1'b1, r, co, ov, lat, nb, held);
      checks++;
      if (r !== ref_result(a, b, 1'b0, 1'b1) || co !== ref_carry(a, b, 1'b0, 1'b1) || lat !== NC) begin
         errors++;
         $display("FAIL after_reset_op: got %h/%b lat=%0d expected %h/%b lat=%0d", r, co, lat,
                  ref_result(a, b, 1'b0, 1'b1), ref_carry(a, b, 1'b0, 1'b1), NC);
      end
      tick();
   endtask

   function automatic logic [OW-1:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return {OW{1'b1}};
         1:       return '0;
         2:       return {1'b0, {(OW-1){1'b1}}};
         3:       return {1'b1, {(OW-1){1'b0}}};
         default: return {$urandom, $urandom};
      endcase
   endfunction

   task automatic test_random();
      logic [OW-1:0] r, a, b; logic co, ov, sub, cin; int lat, nb; bit held;
      int bad;
      bad = 0;
      for (int i = 0; i < 1000; i++) begin
         a   = pick_operand();
         b   = pick_operand();
         sub = 1'($urandom);
         cin = 1'($urandom);
         run_op(a, b, sub, cin, r, co, ov, lat, nb, held);
         checks++;
         if (r !== ref_result(a, b, sub, cin) || co !== ref_carry(a, b, sub, cin) ||
             ov !== ref_ovf(a, b, sub, cin) || lat !== NC || !held) begin
            errors++;
            bad++;
            if (bad <= 10)
               $display("FAIL random_op %0d: a=%h b=%h sub=%b cin=%b got %h/%b/%b lat=%0d expected %h/%b/%b lat=%0d",
                        i, a, b, sub, cin, r, co, ov, lat,
                        ref_result(a, b, sub, cin), ref_carry(a, b, sub, cin),
                        ref_ovf(a, b, sub, cin), NC);
         end
         if ($urandom_range(0, 1) == 0) tick();
      end
   endtask

   initial begin
      test_reset();
      test_carry_chain();
      test_wrap();
      test_sub();
      test_overflow();
      test_ignored_start();
      test_back_to_back();
      test_hold_stable();
      test_reset_mid_run();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
